baud_timer: RTL and testbench

- Parametrised successor of the fixed-count timer in the UART RX path.
- Generates a one-cycle period tick and a mid-period tick from the system clock, with a runtime-loadable divisor, count enable, synchronous restart for start-bit realignment, and periodic or one-shot mode.
- Feeds the RX sampler: `half_tick` marks the bit centre and `tick` marks the bit boundary.

---
 rtl/baud_timer_pkg.sv | 13 +
 rtl/baud_timer.sv | 109 ++++++++++
 tb/tb_baud_timer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_timer_pkg.sv
// Shared types and constants for the baud timer.
package baud_timer_pkg;

    // Timer run state: IDLE holds the counter at zero, RUN counts periods.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    // Smallest usable period; anything below this is clamped on load.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/baud_timer.sv
// Baud-rate timer for the UART RX path: produces a registered bit-boundary
// tick and a bit-centre half_tick from a runtime-loadable divisor.
//
// Handshake-free control: div_load, restart, en and oneshot are level inputs
// sampled on every rising clock edge; there is no valid/ready pairing, a load
// or restart takes effect on the edge where it is seen high.
module baud_timer
    import baud_timer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 434,
    parameter int AUTO_START  = 1
) (
    input  logic             in,        // system clock
    input  logic             rst,       // async reset, active low
    input  logic             en,
    input  logic             restart,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             oneshot,
    output logic             tick,
    output logic             half_tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] RESET_DIV =
        (DEFAULT_DIV < MIN_DIV) ? MIN_DIV_W : WIDTH'(DEFAULT_DIV);
    localparam timer_state_t RESET_STATE = (AUTO_START != 0) ? RUN : IDLE;

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             tick_q, tick_d;
    logic             half_q, half_d;

    logic [WIDTH-1:0] div_in_clamped;
    logic [WIDTH-1:0] last_count;
    logic [WIDTH-1:0] half_count;

    // Clamp incoming divisor and derive the two compare points of the period.
    always_comb begin
        div_in_clamped = (div_in < MIN_DIV_W) ? MIN_DIV_W : div_in;
        last_count     = div_act_q - WIDTH'(1);
        half_count     = (div_act_q >> 1) - WIDTH'(1);
    end

    // Next-state logic: restart first, then IDLE hold, then enabled counting.
    // A divisor loaded this very cycle is already visible to every copy into
    // the active register, so load+restart starts the new period at once.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        div_act_d  = div_act_q;
        div_pend_d = div_load ? div_in_clamped : div_pend_q;
        tick_d     = 1'b0;
        half_d     = 1'b0;

        if (restart) begin
            state_d   = RUN;
            count_d   = '0;
            div_act_d = div_pend_d;
        end else if (state_q == IDLE) begin
            count_d   = '0;
            div_act_d = div_pend_d;
        end else if (en) begin
            if (count_q == half_count) begin
                half_d = 1'b1;
            end
            if (count_q == last_count) begin
                tick_d    = 1'b1;
                count_d   = '0;
                div_act_d = div_pend_d;
                if (oneshot) begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // State, counter, divisor shadow and pulse registers.
    always_ff @(posedge in or negedge rst) begin
        if (!rst) begin
            state_q    <= RESET_STATE;
            count_q    <= '0;
            div_act_q  <= RESET_DIV;
            div_pend_q <= RESET_DIV;
            tick_q     <= 1'b0;
            half_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            tick_q     <= tick_d;
            half_q     <= half_d;
        end
    end

    assign tick      = tick_q;
    assign half_tick = half_q;
    assign busy      = (state_q == RUN);
    assign count     = count_q;

endmodule

// File: tb/tb_baud_timer.sv
// Testbench for baud_timer: directed scenarios plus a randomized run, all
// checked each cycle against a period-level reference model.
module tb_baud_timer;

    localparam int W   = 16;
    localparam int DEF = 10;

    // ---------------- clock / reset ----------------
    logic         clk_in = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         restart = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         oneshot = 1'b0;
    logic         tick;
    logic         half_tick;
    logic         busy;
    logic [W-1:0] count;

    always #5 clk_in = ~clk_in;

    baud_timer #(.WIDTH(W), .DEFAULT_DIV(DEF), .AUTO_START(1)) dut (
        .in        (clk_in),
        .rst       (rst),
        .en        (en),
        .restart   (restart),
        .div_load  (div_load),
        .div_in    (div_in),
        .oneshot   (oneshot),
        .tick      (tick),
        .half_tick (half_tick),
        .busy      (busy),
        .count     (count)
    );

    // ---------------- scoreboard ----------------
    int    checks = 0;
    int    failures = 0;
    int    n_tick = 0;
    int    n_half = 0;
    string ph = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", ph, tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the timer as "running or not", position within the period,
    // the period length in force and the period queued for later.
    bit m_run;
    int m_pos;
    int m_period;
    int m_next_period;
    bit m_tick;
    bit m_half;

    function automatic void model_reset();
        m_run = 1'b1;
        m_pos = 0;
        m_period = DEF;
        m_next_period = DEF;
        m_tick = 1'b0;
        m_half = 1'b0;
    endfunction

    function automatic void model_step(bit r, bit e, bit ld, int din, bit os);
        int queued;
        queued = ld ? ((din < 2) ? 2 : din) : m_next_period;
        m_tick = 1'b0;
        m_half = 1'b0;
        if (r) begin
            m_run = 1'b1;
            m_pos = 0;
            m_period = queued;
        end else if (!m_run) begin
            m_pos = 0;
            m_period = queued;
        end else if (e) begin
            m_half = (m_pos + 1 == m_period / 2);
            if (m_pos + 1 == m_period) begin
                m_tick = 1'b1;
                m_pos = 0;
                m_period = queued;
                m_run = !os;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        m_next_period = queued;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        bit r, e, ld, os;
        int din;
        r = restart; e = en; ld = div_load; os = oneshot; din = int'(div_in);
        @(posedge clk_in);
        #1;
        model_step(r, e, ld, din, os);
        chk("count", 32'(count), 32'(m_pos));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("half_tick", 32'(half_tick), 32'(m_half));
        chk("busy", 32'(busy), 32'(m_run));
        n_tick += int'(tick);
        n_half += int'(half_tick);
    endtask

    task automatic wait_count(input int target);
        int k = 0;
        while (int'(count) != target && k < 200) begin
            step();
            k++;
        end
        chk("wait_count", 32'(count), 32'(target));
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 200);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        model_reset();

        // Reset state (AUTO_START=1 -> busy while held in reset).
        #12;
        chk("count", 32'(count), 0);
        chk("tick", 32'(tick), 0);
        chk("half_tick", 32'(half_tick), 0);
        chk("busy", 32'(busy), 1);
        en  = 1'b1;
        rst = 1'b1;

        // Default period of 10: three ticks and three half ticks in 30 cycles.
        ph = "default";
        n_tick = 0; n_half = 0;
        repeat (30) step();
        chk("n_tick", 32'(n_tick), 3);
        chk("n_half", 32'(n_half), 3);

        // Load 6 at count 3: current period finishes, next one is 6 long.
        ph = "load_mid";
        wait_count(3);
        div_load = 1'b1; div_in = 16'd6;
        step();
        div_load = 1'b0;
        wait_tick(n);
        chk("remaining", 32'(n), 6);
        wait_tick(n);
        chk("new_period", 32'(n), 6);

        // One-shot period of 8 started by restart together with a load.
        ph = "oneshot";
        oneshot = 1'b1; restart = 1'b1; div_load = 1'b1; div_in = 16'd8;
        step();
        restart = 1'b0; div_load = 1'b0;
        n_tick = 0; n_half = 0;
        repeat (20) step();
        chk("n_tick", 32'(n_tick), 1);
        chk("n_half", 32'(n_half), 1);
        chk("busy_end", 32'(busy), 0);
        chk("count_end", 32'(count), 0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_tick = 0; n_half = 0;
        repeat (20) step();
        chk("n_tick2", 32'(n_tick), 1);
        chk("n_half2", 32'(n_half), 1);
        chk("busy_end2", 32'(busy), 0);
        oneshot = 1'b0;

        // Enable held low for 5 cycles at count 4 (P=10).
        ph = "enable";
        restart = 1'b1; div_load = 1'b1; div_in = 16'd10;
        step();
        restart = 1'b0; div_load = 1'b0;
        wait_count(4);
        en = 1'b0;
        n_tick = 0; n_half = 0;
        repeat (5) step();
        chk("held_count", 32'(count), 4);
        chk("held_pulses", 32'(n_tick + n_half), 0);
        en = 1'b1;
        wait_tick(n);
        chk("resume", 32'(n), 6);

        // Restart at count 7 with a new divisor of 4.
        ph = "restart";
        wait_count(7);
        restart = 1'b1; div_load = 1'b1; div_in = 16'd4;
        step();
        restart = 1'b0; div_load = 1'b0;
        chk("tick_on_restart", 32'(tick), 0);
        chk("count_on_restart", 32'(count), 0);
        wait_tick(n);
        chk("period4", 32'(n), 4);
        // Restart exactly at period end must swallow that tick.
        wait_count(3);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("tick_swallowed", 32'(tick), 0);
        // Divisor 1 clamps to 2.
        div_load = 1'b1; div_in = 16'd1;
        step();
        div_load = 1'b0;
        wait_tick(n);
        wait_tick(n);
        chk("clamp_period", 32'(n), 2);

        // Async reset while half_tick is high at count 5.
        ph = "async_reset";
        restart = 1'b1; div_load = 1'b1; div_in = 16'd10;
        step();
        restart = 1'b0; div_load = 1'b0;
        n = 0;
        while (half_tick !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("pre_half", 32'(half_tick), 1);
        chk("pre_count", 32'(count), 5);
        #2 rst = 1'b0;
        #1;
        chk("count", 32'(count), 0);
        chk("tick", 32'(tick), 0);
        chk("half_tick", 32'(half_tick), 0);
        chk("busy", 32'(busy), 1);
        model_reset();
        #2 rst = 1'b1;
        wait_tick(n);
        chk("post_reset_period", 32'(n), 10);

        // Randomized control traffic against the model.
        ph = "random";
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            restart  = ($urandom_range(0, 29) == 0);
            div_load = ($urandom_range(0, 19) == 0);
            div_in   = W'($urandom_range(0, 12));
            oneshot  = ($urandom_range(0, 9) == 0);
            step();
        end
        restart = 1'b0; div_load = 1'b0; oneshot = 1'b0;

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
